// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Adds two WIDTH-bit operands using a single shared 4-bit ripple slice built
// from four full_adder cells. The slice processes one nibble per clock cycle,
// least-significant nibble first, so a result takes N = WIDTH/4 cycles. The
// carry between nibbles is held in a register. Operands arrive and results
// leave through valid/ready handshakes.
//
// Optional feature macro: NSA_SUB_EN
//   When defined, the 'sub' port exists. sub = 1 computes (a - b) mod
//   2^WIDTH by inverting B and forcing the initial carry to 1. In that case
//   cout = 1 means no borrow occurred.
//
// Parameters:
//   WIDTH      operand/result width; must be a multiple of 4 and >= 4
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       WIDTH-bit operands, sampled on the accept edge
//   cin        carry into nibble 0, sampled on the accept edge
//   sub        subtract request (only with NSA_SUB_EN)
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result, stable throughout DONE
//   cout       carry out of the top nibble
//   busy       high while in RUN or DONE
// ---------------------------------------------------------------------------

// One-bit full adder cell; four of these form the shared nibble slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_shifted;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    step_q;

    logic [3:0]       nib_b;
    logic [3:0]       slice_sum;
    logic [4:0]       ripple;
    logic             last_step;
    logic             start_carry;

    // B is inverted per nibble during subtraction; subtraction also forces
    // the initial carry to 1 so that a + ~b + 1 = a - b.
`ifdef NSA_SUB_EN
    logic sub_q;

    assign nib_b       = op_b[3:0] ^ {4{sub_q}};
    assign start_carry = sub ? 1'b1 : cin;

    // The subtract request is captured once on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sub_q <= sub;
        end
    end
`else
    assign nib_b       = op_b[3:0];
    assign start_carry = cin;
`endif

    // Shared 4-bit ripple slice. It always works on the lowest nibble of the
    // shifting operand registers, using the registered inter-nibble carry.
    assign ripple[0] = carry_q;

    for (genvar i = 0; i < 4; i++) begin : g_slice
        full_adder u_fa (
            .a  (op_a[i]),
            .b  (nib_b[i]),
            .ci (ripple[i]),
            .s  (slice_sum[i]),
            .co (ripple[i+1])
        );
    end

    // Each slice result enters sum from the top. After N steps the first
    // nibble has travelled down to sum[3:0].
    if (WIDTH == 4) begin : g_sum_narrow
        assign sum_shifted = slice_sum;
    end else begin : g_sum_wide
        assign sum_shifted = {slice_sum, sum_q[WIDTH-1:4]};
    end

    assign last_step = (step_q == CW'(N - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. in_valid is only looked at in IDLE, so a beat offered
    // while busy is ignored and must be held by the producer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = RUN;
            RUN:  if (last_step) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Datapath. Operands are captured on accept and shifted right one nibble
    // per RUN cycle. The carry from the final step becomes cout. Nothing
    // changes in DONE, so sum and cout hold until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a    <= a;
                        op_b    <= b;
                        carry_q <= start_carry;
                        step_q  <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_shifted;
                    op_a    <= op_a >> 4;
                    op_b    <= op_b >> 4;
                    carry_q <= ripple[4];
                    step_q  <= step_q + CW'(1);
                    if (last_step) begin
                        cout_q <= ripple[4];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are decoded from state or taken straight from registers, so
    // there is no combinational path from in_valid or out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
//
// Self-checking bench for nibble_serial_adder_ctrl with WIDTH = 16. It runs
// a table of directed vectors, hand-written backpressure and reset-abort
// sequences, and randomized transactions. Results are compared against an
// arithmetic reference model. Subtract vectors are built only when
// NSA_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH   = 16;
    localparam int N       = WIDTH / 4;
    localparam int TIMEOUT = 20;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub_req;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t table_v[8];

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NSA_SUB_EN
        .sub       (sub_req),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full-precision arithmetic, with bit 16 as cout.
    function automatic logic [16:0] ref_model(input logic [15:0] ta, input logic [15:0] tb,
                                              input logic tcin, input logic tsub);
        if (tsub)
            return {1'b0, ta} + {1'b0, ~tb} + 17'd1;
        else
            return {1'b0, ta} + {1'b0, tb} + 17'(tcin);
    endfunction

    // Counts one comparison and reports it when it fails.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offers one operand beat from IDLE and returns just after the accept
    // edge. The operand inputs are then scrambled, which shows they were
    // sampled only on that edge.
    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tcin, input logic tsub);
        checkOutput("in_ready before accept", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub_req  = tsub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
        sub_req  = 1'($urandom);
    endtask

    // Counts clock edges after the accept edge until out_valid is seen, with
    // a fixed upper bound on the wait.
    task automatic waitResult(output int lat);
        lat = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full transaction with the consumer always ready.
    task automatic runTxn(input string name, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [15:0] exp_sum, input logic exp_cout);
        int lat;
        out_ready = 1'b1;
        applyStimulus(ta, tb, tcin, tsub);
        waitResult(lat);
        checkOutput({name, " latency"}, 32'(lat), 32'(N));
        checkOutput({name, " sum"}, 32'(sum), 32'(exp_sum));
        checkOutput({name, " cout"}, 32'(cout), 32'(exp_cout));
        @(posedge clk); #1;
        checkOutput({name, " in_ready after"}, 32'(in_ready), 32'd1);
        checkOutput({name, " out_valid after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [16:0] expv;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        int          hold;

        table_v[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        table_v[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        table_v[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        table_v[3] = '{16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0};
        table_v[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
        table_v[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        table_v[6] = '{16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0};
        table_v[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub_req   = 1'b0;
        out_ready = 1'b0;

        // Reset state, checked while reset is still held.
        #12;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset sum", 32'(sum), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            runTxn($sformatf("vec%0d", i), table_v[i].a, table_v[i].b, table_v[i].cin, 1'b0,
                   table_v[i].exp_sum, table_v[i].exp_cout);
        end

        // Backpressure: hold the result for 3 cycles while a stray beat is
        // offered. The stray beat must be ignored.
        out_ready = 1'b0;
        applyStimulus(16'h00F0, 16'h0F10, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("bp latency", 32'(lat), 32'(N));
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'h1111;
            b        = 16'h2222;
            @(posedge clk); #1;
            checkOutput("bp out_valid held", 32'(out_valid), 32'd1);
            checkOutput("bp sum held", 32'(sum), 32'h1000);
            checkOutput("bp in_ready low", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp in_ready after release", 32'(in_ready), 32'd1);
        checkOutput("bp busy after release", 32'(busy), 32'd0);
        @(posedge clk); #1;
        checkOutput("bp stray beat ignored", 32'(busy), 32'd0);

        // Reset mid-RUN aborts the transaction without producing a result.
        out_ready = 1'b1;
        applyStimulus(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("abort busy in RUN", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort sum", 32'(sum), 32'd0);
        checkOutput("abort cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        checkOutput("abort no out_valid", 32'(seen), 32'd0);
        runTxn("after abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

`ifdef NSA_SUB_EN
        runTxn("sub 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        runTxn("sub 7-5", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
`endif

        // Randomized transactions with a random consumer stall.
        for (int i = 0; i < 40; i++) begin
            ra   = 16'($urandom_range(0, 65535));
            rb   = 16'($urandom_range(0, 65535));
            rc   = 1'($urandom_range(0, 1));
`ifdef NSA_SUB_EN
            rs   = 1'($urandom_range(0, 1));
`else
            rs   = 1'b0;
`endif
            hold = $urandom_range(0, 3);
            expv = ref_model(ra, rb, rc, rs);
            out_ready = (hold == 0);
            applyStimulus(ra, rb, rc, rs);
            waitResult(lat);
            checkOutput($sformatf("rnd%0d latency", i), 32'(lat), 32'(N));
            checkOutput($sformatf("rnd%0d sum", i), 32'(sum), 32'(expv[15:0]));
            checkOutput($sformatf("rnd%0d cout", i), 32'(cout), 32'(expv[16]));
            repeat (hold) begin
                @(posedge clk); #1;
            end
            checkOutput($sformatf("rnd%0d sum stable", i), 32'(sum), 32'(expv[15:0]));
            checkOutput($sformatf("rnd%0d out_valid stable", i), 32'(out_valid), 32'd1);
            out_ready = 1'b1;
            @(posedge clk); #1;
            checkOutput($sformatf("rnd%0d in_ready after", i), 32'(in_ready), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
